encoder_8_to_3: RTL and testbench
=================================

Name: encoder_8_to_3

Overview:
Registered 8-to-3 binary encoder with an active-high enable. It converts a one-hot 8-bit request vector into its 3-bit bit index and registers the result. Status flags mark a valid (non-zero) input and a multi-hot (illegal one-hot) input. It is a small leaf block that feeds downstream select/mux logic, which consumes the code one clock after the input is presented.

Parameters:
IN_WIDTH, 8, width of the request vector; the design is verified only at 8.
OUT_WIDTH, 3, width of the encoded index; must equal clog2(IN_WIDTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high; clears all registered outputs.
Enable  input  1  encoder enable; when 0 the outputs are forced to their idle values on the next edge.
In  input  8  request vector; nominally one-hot.
Out  output  3  registered encoded index of the highest set bit of In.
Valid  output  1  registered; 1 when Enable=1 and In is non-zero.
Multi  output  1  registered; 1 when Enable=1 and more than one bit of In is set.

Behaviour:
- One clock, no other state. Nothing on the input path is combinational to the outputs.
- Reset (rst=1, asynchronous):
  - Out=3'b000, Valid=0, Multi=0 immediately, independent of clk.
  - The outputs hold these values while rst is high.
- Reset mid-operation:
  - Assertion clears the outputs at once and discards the in-flight result.
  - The first capture happens at the first rising clk edge after rst deasserts.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- Enable=0 at the sampling edge: Out=0, Valid=0, Multi=0, regardless of In.
- Enable=1 at the sampling edge:
  - Out = index of the highest-numbered set bit of In (priority encode, MSB wins).
    - In=8'b0000_0001 -> 0
    - In=8'b0000_0010 -> 1
    - ...
    - In=8'b1000_0000 -> 7
  - In=8'h00: Out=0, Valid=0, Multi=0. Out=0 alone is ambiguous with In[0]; downstream logic must qualify Out with Valid.
  - Exactly one bit set: Valid=1, Multi=0.
  - Two or more bits set: Valid=1, Multi=1, and Out is the highest set index (e.g. 8'b0010_0100 -> 5).
- Enable and In are sampled together at the same edge. A change on either input takes effect on the next edge only.
- X/Z on In while Enable=0 must not propagate to the outputs.

Test Plan:
1. Assert rst with clk toggling, Enable=1, In=8'h80; deassert rst -> outputs are 0/0/0 while rst is high; one edge after deassertion Out=7, Valid=1, Multi=0.
2. Enable=0; sweep In=2**i for i=0..7, one value per cycle -> Out=0, Valid=0, Multi=0 every cycle.
3. Enable=1; sweep In=2**i for i=0..7 -> one cycle after each input, Out=i, Valid=1, Multi=0.
4. Enable=1, In=8'h00 -> Out=0, Valid=0, Multi=0. Then In=8'h01 -> Out=0, Valid=1, distinguishing bit 0 from no request.
5. Enable=1, multi-hot inputs: In=8'b0010_0100 -> Out=5, Multi=1; In=8'hFF -> Out=7, Multi=1; In=8'b0000_0011 -> Out=1, Multi=1.
6. Enable=1, In=8'h40 streaming; pulse rst asynchronously between edges -> outputs drop to 0 before the next edge. Then toggle Enable 1->0 -> outputs go idle one edge later.

Source files
------------

// File: rtl/encoder_8_to_3.sv
// Registered priority encoder: index of the highest set request bit, plus
// valid / multi-hot flags, presented one clock after the request is sampled.
module encoder_8_to_3 #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Enable,
  input  logic [IN_WIDTH-1:0]  In,
  output logic [OUT_WIDTH-1:0] Out,
  output logic                 Valid,
  output logic                 Multi
);

  logic [OUT_WIDTH-1:0] out_d,   out_q;
  logic                 valid_d, valid_q;
  logic                 multi_d, multi_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    out_d   = '0;
    valid_d = 1'b0;
    multi_d = 1'b0;
    // In is only examined under Enable, so X/Z on an idle request bus stays out of the flops.
    if (Enable) begin
      // Ascending scan: the last hit is the highest set bit, so the MSB wins.
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (In[i]) out_d = OUT_WIDTH'(i);
      end
      valid_d = |In;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_d = |(In & (In - IN_WIDTH'(1)));
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign Out   = out_q;
  assign Valid = valid_q;
  assign Multi = multi_q;

endmodule

// File: tb/tb_encoder_8_to_3.sv
// Self-checking bench for encoder_8_to_3: directed scenarios plus random
// stimulus compared against an arithmetic reference model.
module tb_encoder_8_to_3;

  logic       clk;
  logic       rst;
  logic       Enable;
  logic [7:0] In;
  logic [2:0] Out;
  logic       Valid;
  logic       Multi;

  int checks = 0;
  int errors = 0;

  encoder_8_to_3 #(.IN_WIDTH(8), .OUT_WIDTH(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .Enable (Enable),
    .In     (In),
    .Out    (Out),
    .Valid  (Valid),
    .Multi  (Multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {Out, Valid, Multi}: highest set index is floor(log2(v)).
  function automatic logic [4:0] model(input logic en, input logic [7:0] v);
    int idx;
    if (!en || v == 8'h00) return 5'b0;
    idx = $clog2(int'(v) + 1) - 1;
    return {3'(idx), 1'b1, ($countones(v) > 1)};
  endfunction

  // Present inputs after the falling edge, then sample 1 time unit past the rising edge.
  task automatic apply(input logic en, input logic [7:0] v);
    @(negedge clk);
    Enable = en;
    In     = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [4:0] exp;
    Enable = 1'b1;
    In     = 8'h80;
    rst    = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({Out, Valid, Multi} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async: got out=%0d valid=%0b multi=%0b, expected 0/0/0", Out, Valid, Multi);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({Out, Valid, Multi} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got out=%0d valid=%0b multi=%0b, expected 0/0/0", k, Out, Valid, Multi);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp = {3'd7, 1'b1, 1'b0};
    checks++;
    if ({Out, Valid, Multi} !== exp) begin
      errors++;
      $display("FAIL reset_release: got out=%0d valid=%0b multi=%0b, expected 7/1/0", Out, Valid, Multi);
    end
  endtask

  task automatic test_enable_off;
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 8'(1 << i);
      apply(1'b0, v);
      checks++;
      if ({Out, Valid, Multi} !== 5'b0) begin
        errors++;
        $display("FAIL enable_off In=%h: got out=%0d valid=%0b multi=%0b, expected 0/0/0", v, Out, Valid, Multi);
      end
    end
    apply(1'b0, 8'bx);
    checks++;
    if ({Out, Valid, Multi} !== 5'b0) begin
      errors++;
      $display("FAIL enable_off_x: got out=%b valid=%b multi=%b, expected 0/0/0", Out, Valid, Multi);
    end
    apply(1'b0, 8'bz);
    checks++;
    if ({Out, Valid, Multi} !== 5'b0) begin
      errors++;
      $display("FAIL enable_off_z: got out=%b valid=%b multi=%b, expected 0/0/0", Out, Valid, Multi);
    end
  endtask

  task automatic test_onehot_sweep;
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 8'(1 << i);
      apply(1'b1, v);
      checks++;
      if ({Out, Valid, Multi} !== {3'(i), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL onehot In=%h: got out=%0d valid=%0b multi=%0b, expected %0d/1/0", v, Out, Valid, Multi, i);
      end
    end
  endtask

  task automatic test_zero_vs_bit0;
    apply(1'b1, 8'h00);
    checks++;
    if ({Out, Valid, Multi} !== 5'b0) begin
      errors++;
      $display("FAIL zero_input: got out=%0d valid=%0b multi=%0b, expected 0/0/0", Out, Valid, Multi);
    end
    apply(1'b1, 8'h01);
    checks++;
    if ({Out, Valid, Multi} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bit0_input: got out=%0d valid=%0b multi=%0b, expected 0/1/0", Out, Valid, Multi);
    end
  endtask

  task automatic test_multi_hot;
    logic [7:0] vecs [3];
    logic [2:0] idx  [3];
    vecs = '{8'b0010_0100, 8'hFF, 8'b0000_0011};
    idx  = '{3'd5, 3'd7, 3'd1};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, vecs[i]);
      checks++;
      if ({Out, Valid, Multi} !== {idx[i], 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL multi_hot In=%h: got out=%0d valid=%0b multi=%0b, expected %0d/1/1", vecs[i], Out, Valid, Multi, idx[i]);
      end
    end
  endtask

  task automatic test_async_reset_and_disable;
    apply(1'b1, 8'h40);
    checks++;
    if ({Out, Valid, Multi} !== {3'd6, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stream_pre_reset: got out=%0d valid=%0b multi=%0b, expected 6/1/0", Out, Valid, Multi);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({Out, Valid, Multi} !== 5'b0) begin
      errors++;
      $display("FAIL midcycle_reset: got out=%0d valid=%0b multi=%0b, expected 0/0/0", Out, Valid, Multi);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({Out, Valid, Multi} !== 5'b0) begin
      errors++;
      $display("FAIL reset_discard: got out=%0d valid=%0b multi=%0b, expected 0/0/0", Out, Valid, Multi);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Out, Valid, Multi} !== {3'd6, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_capture: got out=%0d valid=%0b multi=%0b, expected 6/1/0", Out, Valid, Multi);
    end
    @(negedge clk);
    Enable = 1'b0;
    #1;
    checks++;
    if ({Out, Valid, Multi} !== {3'd6, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL disable_before_edge: got out=%0d valid=%0b multi=%0b, expected 6/1/0", Out, Valid, Multi);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Out, Valid, Multi} !== 5'b0) begin
      errors++;
      $display("FAIL disable_after_edge: got out=%0d valid=%0b multi=%0b, expected 0/0/0", Out, Valid, Multi);
    end
  endtask

  task automatic test_random;
    logic       en;
    logic [7:0] v;
    logic [4:0] exp;
    for (int n = 0; n < 300; n++) begin
      en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       v = 8'(1 << $urandom_range(0, 7));
        1:       v = 8'h00;
        default: v = 8'($urandom);
      endcase
      exp = model(en, v);
      apply(en, v);
      checks++;
      if ({Out, Valid, Multi} !== exp) begin
        errors++;
        $display("FAIL random #%0d En=%0b In=%h: got out=%0d valid=%0b multi=%0b, expected %0d/%0b/%0b",
                 n, en, v, Out, Valid, Multi, exp[4:2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    Enable = 1'b0;
    In     = 8'h00;
    rst    = 1'b0;
    test_reset();
    test_enable_off();
    test_onehot_sweep();
    test_zero_vs_bit0();
    test_multi_hot();
    test_async_reset_and_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
